pushbutton_conditioner: RTL and testbench
=========================================

# pushbutton_conditioner

Input-conditioning stage between the board pushbuttons and the 4-bit processor's `pushbuttons` input port. Each raw button line is synchronised into `clk`, debounced with a per-bit counter, and edge-detected into a sticky press latch that the processor clears when it executes `IN`. The value driven to the processor's tri-state input buffer is either the debounced level or the sticky press latch, selected by parameter.

## Interface

Parameters:
- `WIDTH`, 4: number of button lines; matches the processor data width.
- `DEBOUNCE_CYCLES`, 16: consecutive cycles a synchronised input must differ from the stable value before it is accepted. Legal range is 2 or more. Boards use about 2^16; benches use small values.
- `STICKY_OUT`, 1: selects the source of `btn_to_cpu`. 1 selects `btn_pressed`. 0 selects `btn_level`.

Ports:
- `clk`, in, 1: clock. Same clock as the processor.
- `reset`, in, 1: asynchronous, active-high.
- `btn_raw`, in, WIDTH: asynchronous button inputs, active-high.
- `rd_strobe`, in, 1: one-cycle pulse when the processor reads the port, driven from the `IN` decode enable. It clears the sticky latch.
- `btn_level`, out, WIDTH: debounced stable level, registered.
- `btn_pressed`, out, WIDTH: sticky rising-edge latch, registered.
- `btn_to_cpu`, out, WIDTH: mux of the two registered outputs above. Feeds the processor `pushbuttons` input.

## Operation

- Reset values: sync stages 0, `btn_level` 0, `btn_pressed` 0, all counters 0. `btn_to_cpu` is therefore 0.
- Reset is asynchronous. Asserting it mid-debounce discards any count in progress. A button held through reset release is accepted again through the full debounce path, which produces a new press event.
- Synchroniser: two flops per bit, `s1 <= btn_raw`, `s2 <= s1`. Only `s2` is used downstream.
- Per-bit debounce uses a counter of width `$clog2(DEBOUNCE_CYCLES)`:
  - `s2 == level`: count is cleared to 0.
  - `s2 != level` and `count < DEBOUNCE_CYCLES-1`: count increments by 1.
  - `s2 != level` and `count == DEBOUNCE_CYCLES-1`: `level <= s2` and count is cleared to 0.
  - The counter never wraps.
- Any mismatch shorter than `DEBOUNCE_CYCLES` cycles is rejected because the count clears. Bounce therefore restarts the qualification window.
- Press detect: `rise = s2 & ~level & (count == DEBOUNCE_CYCLES-1)`. `rise` is asserted on exactly the edge where `level` goes 0→1. Falling transitions generate no event.
- Sticky latch, per bit: `pressed <= rise | (pressed & ~rd_strobe)`.
  - Set has priority over clear. A press that is accepted in the same cycle as `rd_strobe` survives for the next read.
  - `rd_strobe` clears all bits at once.
- The bits are fully independent. Simultaneous transitions on several bits are each handled by their own counters.

## Timing

- `btn_raw` changes before rising edge E0 and then stays constant:
  - `s1` updates at E0 and `s2` at E1.
  - The count runs on edges E2 through E(1+N-1).
  - `btn_level` and `btn_pressed` update at edge E(1+N), where N = `DEBOUNCE_CYCLES`.
  - Total latency is N+2 edges.
- `rd_strobe` clears `btn_pressed` on the edge where it is sampled high. The processor samples `btn_to_cpu` combinationally in the same cycle, so it reads the pre-clear value. This is read-then-clear semantics.
- The block has no combinational path from `btn_raw` or `rd_strobe` to any output.

## Structure

- Shared package `io_pkg`:
  - `IO_WIDTH = 4`.
  - Default `DEBOUNCE_CYCLES` constants: `DEB_SIM = 4` and `DEB_BOARD = 65536`.
- Sub-module `btn_debounce`, single bit: contains the synchroniser, counter, level register and `rise` output. It is instantiated WIDTH times in a generate loop.
- The sticky latch and output mux live in the top module.

## Test plan

N=4 for all scenarios.
1. Reset, then hold `btn_raw=0000` for 20 cycles → all outputs stay 0 and all counters stay 0.
2. Step `btn_raw` 0000→0001 before E0 → `btn_level=0001` and `btn_pressed=0001` appear exactly at E5, with no earlier change.
3. Apply a bounce pattern on bit 2 of high 2 cycles, low 1, high 3, low 1, then steady high → no accept until 4 consecutive high `s2` cycles. Exactly one press event, `btn_pressed=0100`.
4. With `btn_pressed=0101`, pulse `rd_strobe` for 1 cycle → `btn_to_cpu` reads 0101 during the strobe and 0000 on the following cycle.
5. Align the bit 3 accept edge with `rd_strobe` while bit 0 is already set → after the edge `btn_pressed=1000`. Bit 0 is cleared and bit 3 is retained.
6. Assert `reset` at count=2 during a bit 1 press, keep the button held, then release reset at edge R → all outputs 0, then `btn_level=0010` and `btn_pressed=0010` at R+5 relative to the first sampling edge.
7. With `STICKY_OUT=0`, press and release bit 1 → `btn_to_cpu` follows `btn_level`, and `rd_strobe` has no effect on it.

Source files
------------

// File: rtl/io_pkg.sv
// Shared I/O constants for the 4-bit processor's input-conditioning blocks.
// Debounce defaults for simulation and for real boards.
package io_pkg;
  localparam int IO_WIDTH  = 4;
  localparam int DEB_SIM   = 4;
  localparam int DEB_BOARD = 65536;

  typedef logic [IO_WIDTH-1:0] btn_t;
endpackage

// File: rtl/btn_debounce.sv
// Single-bit pushbutton path: 2-flop synchroniser, qualification counter,
// debounced level register and a one-cycle rise indication.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_max;

  assign at_max = (cnt_q == CMAX);

  // Any sample matching the stable level restarts the window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (s2_q != level_q) begin
      if (at_max) level_d = s2_q;
      else        cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = s2_q & ~level_q & at_max;
endmodule

// File: rtl/pushbutton_conditioner.sv
// Conditions raw pushbuttons for the processor IN port: debounce per bit,
// sticky press latch cleared by the read strobe, selectable output source.
module pushbutton_conditioner
  import io_pkg::*;
#(
  parameter int WIDTH           = IO_WIDTH,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STICKY_OUT      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  input  logic             rd_strobe,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_pressed,
  output logic [WIDTH-1:0] btn_to_cpu
);
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] pressed_q, pressed_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (btn_raw[i]),
      .level_o(level[i]),
      .rise_o (rise[i])
    );
  end

  // A press landing on the read edge wins so it is seen by the next read.
  assign pressed_d = rise | (pressed_q & ~{WIDTH{rd_strobe}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pressed_q <= '0;
    else       pressed_q <= pressed_d;
  end

  assign btn_level   = level;
  assign btn_pressed = pressed_q;
  assign btn_to_cpu  = (STICKY_OUT != 0) ? pressed_q : level;
endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Self-checking bench: two instances (sticky and level output) against
// a window-based reference model of the debounce and press latch.
module tb_pushbutton_conditioner;
  import io_pkg::*;

  localparam int N = DEB_SIM;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_raw = '0;
  logic       rd_strobe = 1'b0;
  logic [3:0] lvl_s, prs_s, cpu_s;
  logic [3:0] lvl_l, prs_l, cpu_l;
  logic [23:0] act;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pushbutton_conditioner #(
    .WIDTH(4), .DEBOUNCE_CYCLES(N), .STICKY_OUT(1)
  ) u_stk (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .rd_strobe(rd_strobe), .btn_level(lvl_s),
    .btn_pressed(prs_s), .btn_to_cpu(cpu_s)
  );

  pushbutton_conditioner #(
    .WIDTH(4), .DEBOUNCE_CYCLES(N), .STICKY_OUT(0)
  ) u_lvl (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .rd_strobe(rd_strobe), .btn_level(lvl_l),
    .btn_pressed(prs_l), .btn_to_cpu(cpu_l)
  );

  assign act = {lvl_s, prs_s, cpu_s, lvl_l, prs_l, cpu_l};

  // Reference model: s2 is raw delayed two edges; a level flips once
  // the last N samples since the previous flip all disagree with it.
  logic [3:0] m_lvl, m_prs;
  logic [3:0] m_sq[$];
  bit         m_win[4][$];

  function automatic void model_reset();
    m_lvl = '0;
    m_prs = '0;
    m_sq  = '{4'b0, 4'b0};
    for (int b = 0; b < 4; b++) m_win[b].delete();
  endfunction

  function automatic void model_edge(logic [3:0] r, logic d);
    logic [3:0] s2, rise;
    bit all;
    s2 = m_sq[0];
    void'(m_sq.pop_front());
    m_sq.push_back(r);
    rise = '0;
    for (int b = 0; b < 4; b++) begin
      m_win[b].push_back(s2[b]);
      if (m_win[b].size() > N) void'(m_win[b].pop_front());
      all = (m_win[b].size() == N);
      for (int i = 0; i < m_win[b].size(); i++)
        if (m_win[b][i] == m_lvl[b]) all = 0;
      if (all) begin
        m_lvl[b] = s2[b];
        rise[b]  = s2[b];
        m_win[b].delete();
      end
    end
    m_prs = rise | (m_prs & ~{4{d}});
  endfunction

  function automatic logic [23:0] expv();
    return {m_lvl, m_prs, m_prs, m_lvl, m_prs, m_lvl};
  endfunction

  task automatic step(input logic [3:0] r, input logic d);
    btn_raw   = r;
    rd_strobe = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
  endtask

  task automatic test_reset();
    btn_raw = '0;
    rd_strobe = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (act !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_state got %h want %h", act, 24'h0);
    end
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 20; k++) begin
      step(4'b0000, 1'b0);
      n_chk++;
      if (act !== 24'h0) begin
        n_fail++;
        $display("FAIL idle_zero k=%0d got %h want %h", k, act, 24'h0);
      end
    end
  endtask

  task automatic test_step_latency();
    logic [3:0] want;
    for (int k = 0; k <= 5; k++) begin
      step(4'b0001, 1'b0);
      want = (k == 5) ? 4'b0001 : 4'b0000;
      n_chk++;
      if ({lvl_s, prs_s} !== {want, want} || act !== expv()) begin
        n_fail++;
        $display("FAIL step_latency E%0d got lvl=%b prs=%b all=%h want lvl=%b prs=%b all=%h",
                 k, lvl_s, prs_s, act, want, want, expv());
      end
    end
  endtask

  task automatic test_bounce();
    int pat[15] = '{1,1,0,1,1,1,0,1,1,1,1,1,1,1,1};
    step(4'b0001, 1'b1);
    for (int i = 0; i < 15; i++) begin
      step(4'b0001 | (4'(pat[i]) << 2), 1'b0);
      n_chk++;
      if (act !== expv()) begin
        n_fail++;
        $display("FAIL bounce i=%0d got %h want %h", i, act, expv());
      end
    end
    n_chk++;
    if (prs_s !== 4'b0100) begin
      n_fail++;
      $display("FAIL bounce_final got %b want %b", prs_s, 4'b0100);
    end
  endtask

  task automatic test_read_clear();
    for (int k = 0; k < 16; k++) begin
      step((k < 8) ? 4'b0100 : 4'b0101, 1'b0);
      n_chk++;
      if (act !== expv()) begin
        n_fail++;
        $display("FAIL rc_setup k=%0d got %h want %h", k, act, expv());
      end
    end
    btn_raw = 4'b0101;
    rd_strobe = 1'b1;
    #1;
    n_chk++;
    if (cpu_s !== 4'b0101) begin
      n_fail++;
      $display("FAIL rc_during got %b want %b", cpu_s, 4'b0101);
    end
    @(posedge clk);
    model_edge(4'b0101, 1'b1);
    #1;
    rd_strobe = 1'b0;
    n_chk++;
    if (cpu_s !== 4'b0000 || act !== expv()) begin
      n_fail++;
      $display("FAIL rc_after got %b (%h) want %b (%h)",
               cpu_s, act, 4'b0000, expv());
    end
  endtask

  task automatic test_set_clear_collision();
    for (int k = 0; k < 16; k++)
      step((k < 8) ? 4'b0100 : 4'b0101, 1'b0);
    n_chk++;
    if (prs_s !== 4'b0001) begin
      n_fail++;
      $display("FAIL coll_setup got %b want %b", prs_s, 4'b0001);
    end
    for (int k = 0; k <= 5; k++) step(4'b1101, k == 5);
    n_chk++;
    if (prs_s !== 4'b1000 || act !== expv()) begin
      n_fail++;
      $display("FAIL coll_priority got %b (%h) want %b (%h)",
               prs_s, act, 4'b1000, expv());
    end
    step(4'b1101, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [3:0] want;
    btn_raw = 4'b0000;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) step(4'b0010, 1'b0);
    reset = 1'b1;
    #1;
    n_chk++;
    if (act !== 24'h0) begin
      n_fail++;
      $display("FAIL mid_reset_zero got %h want %h", act, 24'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int k = 0; k <= 5; k++) begin
      step(4'b0010, 1'b0);
      want = (k == 5) ? 4'b0010 : 4'b0000;
      n_chk++;
      if ({lvl_s, prs_s} !== {want, want} || act !== expv()) begin
        n_fail++;
        $display("FAIL reset_repress R+%0d got lvl=%b prs=%b want %b",
                 k, lvl_s, prs_s, want);
      end
    end
  endtask

  task automatic test_level_mode();
    logic [3:0] r;
    for (int k = 0; k < 36; k++) begin
      r = (k >= 12 && k < 24) ? 4'b0010 : 4'b0000;
      step(r, $urandom_range(0, 2) == 0);
      n_chk++;
      if (cpu_l !== m_lvl || act !== expv()) begin
        n_fail++;
        $display("FAIL level_mode k=%0d got cpu=%b (%h) want cpu=%b (%h)",
                 k, cpu_l, act, m_lvl, expv());
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    int hold;
    r = '0;
    hold = 0;
    for (int k = 0; k < 400; k++) begin
      if (hold == 0) begin
        r = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 8);
      end
      hold--;
      step(r, $urandom_range(0, 7) == 0);
      n_chk++;
      if (act !== expv()) begin
        n_fail++;
        $display("FAIL random k=%0d got %h want %h", k, act, expv());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_step_latency();
    test_bounce();
    test_read_clear();
    test_set_clear_collision();
    test_reset_mid();
    test_level_mode();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
